seg_axil_master: RTL and testbench



---
 rtl/seg_axil_master.sv | 257 +++++++++++++++++++++++++
 tb/tb_seg_axil_master.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_axil_master.sv
// seg_axil_master: single-transaction AXI4-Lite master for the segmentation accelerator s00_axi port.
// Latency: command accept to rsp_valid is 3 cycles minimum, +1 per AXI stall cycle.
// Backpressure: cmd_ready low from accept until the rsp handshake; response held while rsp_ready is low.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   cmd_valid/cmd_ready          command handshake (cmd_we, cmd_addr, cmd_wdata, cmd_wstrb)
//   rsp_valid/rsp_ready          response handshake (rsp_rdata, rsp_resp, rsp_timeout)
//   m00_axi_*                    AXI4-Lite master channels AW, W, B, AR, R
module seg_axil_master #(
  parameter int C_S00_AXI_DATA_WIDTH = 32,
  parameter int C_S00_AXI_ADDR_WIDTH = 4,
  parameter int TIMEOUT_CYCLES       = 256
) (
  input  logic                                clk,
  input  logic                                rst,
  // command port
  input  logic                                cmd_valid,
  output logic                                cmd_ready,
  input  logic                                cmd_we,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [C_S00_AXI_DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [C_S00_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
  // response port
  output logic                                rsp_valid,
  input  logic                                rsp_ready,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                          rsp_resp,
  output logic                                rsp_timeout,
  // AXI4-Lite write address
  output logic [C_S00_AXI_ADDR_WIDTH-1:0]     m00_axi_awaddr,
  output logic [2:0]                          m00_axi_awprot,
  output logic                                m00_axi_awvalid,
  input  logic                                m00_axi_awready,
  // AXI4-Lite write data
  output logic [C_S00_AXI_DATA_WIDTH-1:0]     m00_axi_wdata,
  output logic [C_S00_AXI_DATA_WIDTH/8-1:0]   m00_axi_wstrb,
  output logic                                m00_axi_wvalid,
  input  logic                                m00_axi_wready,
  // AXI4-Lite write response
  input  logic [1:0]                          m00_axi_bresp,
  input  logic                                m00_axi_bvalid,
  output logic                                m00_axi_bready,
  // AXI4-Lite read address
  output logic [C_S00_AXI_ADDR_WIDTH-1:0]     m00_axi_araddr,
  output logic [2:0]                          m00_axi_arprot,
  output logic                                m00_axi_arvalid,
  input  logic                                m00_axi_arready,
  // AXI4-Lite read data
  input  logic [C_S00_AXI_DATA_WIDTH-1:0]     m00_axi_rdata,
  input  logic [1:0]                          m00_axi_rresp,
  input  logic                                m00_axi_rvalid,
  output logic                                m00_axi_rready
);

  localparam int DW   = C_S00_AXI_DATA_WIDTH;
  localparam int AW   = C_S00_AXI_ADDR_WIDTH;
  localparam int SW   = C_S00_AXI_DATA_WIDTH / 8;
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  // The counter holds the number of completed outstanding cycles, so the cycle
  // in which it reads TIMEOUT_CYCLES-1 is the last one allowed.
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4,
    RSP     = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [WD_W-1:0]   wd_q, wd_d;

  logic              cmd_ready_d;
  logic              rsp_valid_d;
  logic [DW-1:0]     rsp_rdata_d;
  logic [1:0]        rsp_resp_d;
  logic              rsp_timeout_d;
  logic [AW-1:0]     awaddr_d;
  logic              awvalid_d;
  logic [DW-1:0]     wdata_d;
  logic [SW-1:0]     wstrb_d;
  logic              wvalid_d;
  logic              bready_d;
  logic [AW-1:0]     araddr_d;
  logic              arvalid_d;
  logic              rready_d;

  logic              busy;   // a transaction is outstanding on the AXI side
  logic              done;   // the state's completing handshake happens this cycle
  logic              tmo;

  assign m00_axi_awprot = 3'b000;
  assign m00_axi_arprot = 3'b000;
  assign tmo            = (wd_q == WD_LAST);

  always_comb begin
    state_d       = state_q;
    wd_d          = wd_q;
    cmd_ready_d   = cmd_ready;
    rsp_valid_d   = rsp_valid;
    rsp_rdata_d   = rsp_rdata;
    rsp_resp_d    = rsp_resp;
    rsp_timeout_d = rsp_timeout;
    awaddr_d      = m00_axi_awaddr;
    awvalid_d     = m00_axi_awvalid;
    wdata_d       = m00_axi_wdata;
    wstrb_d       = m00_axi_wstrb;
    wvalid_d      = m00_axi_wvalid;
    bready_d      = m00_axi_bready;
    araddr_d      = m00_axi_araddr;
    arvalid_d     = m00_axi_arvalid;
    rready_d      = m00_axi_rready;
    busy          = 1'b0;
    done          = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          cmd_ready_d = 1'b0;
          wd_d        = '0;
          if (cmd_we) begin
            awaddr_d  = cmd_addr;
            wdata_d   = cmd_wdata;
            wstrb_d   = cmd_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR;
          end else begin
            araddr_d  = cmd_addr;
            arvalid_d = 1'b1;
            state_d   = RD_ADDR;
          end
        end
      end

      WR: begin
        busy = 1'b1;
        if (m00_axi_awvalid && m00_axi_awready) awvalid_d = 1'b0;
        if (m00_axi_wvalid  && m00_axi_wready)  wvalid_d  = 1'b0;
        // A channel whose valid is already low has completed its handshake earlier.
        if ((!m00_axi_awvalid || m00_axi_awready) && (!m00_axi_wvalid || m00_axi_wready)) begin
          done     = 1'b1;
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end

      WR_RESP: begin
        busy = 1'b1;
        if (m00_axi_bvalid) begin
          done          = 1'b1;
          bready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_resp_d    = m00_axi_bresp;
          rsp_timeout_d = 1'b0;
          state_d       = RSP;
        end
      end

      RD_ADDR: begin
        busy = 1'b1;
        if (m00_axi_arready) begin
          done      = 1'b1;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end

      RD_DATA: begin
        busy = 1'b1;
        if (m00_axi_rvalid) begin
          done          = 1'b1;
          rready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = m00_axi_rdata;
          rsp_resp_d    = m00_axi_rresp;
          rsp_timeout_d = 1'b0;
          state_d       = RSP;
        end
      end

      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d     = IDLE;
        cmd_ready_d = 1'b1;
      end
    endcase

    // Watchdog: a completing handshake in the final cycle takes priority over the abort.
    if (busy) begin
      wd_d = wd_q + WD_W'(1);
      if (!done && tmo) begin
        awvalid_d     = 1'b0;
        wvalid_d      = 1'b0;
        bready_d      = 1'b0;
        arvalid_d     = 1'b0;
        rready_d      = 1'b0;
        rsp_valid_d   = 1'b1;
        rsp_rdata_d   = '0;
        rsp_resp_d    = 2'b10;
        rsp_timeout_d = 1'b1;
        state_d       = RSP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      wd_q            <= '0;
      cmd_ready       <= 1'b1;
      rsp_valid       <= 1'b0;
      rsp_rdata       <= '0;
      rsp_resp        <= 2'b00;
      rsp_timeout     <= 1'b0;
      m00_axi_awaddr  <= '0;
      m00_axi_awvalid <= 1'b0;
      m00_axi_wdata   <= '0;
      m00_axi_wstrb   <= '0;
      m00_axi_wvalid  <= 1'b0;
      m00_axi_bready  <= 1'b0;
      m00_axi_araddr  <= '0;
      m00_axi_arvalid <= 1'b0;
      m00_axi_rready  <= 1'b0;
    end else begin
      state_q         <= state_d;
      wd_q            <= wd_d;
      cmd_ready       <= cmd_ready_d;
      rsp_valid       <= rsp_valid_d;
      rsp_rdata       <= rsp_rdata_d;
      rsp_resp        <= rsp_resp_d;
      rsp_timeout     <= rsp_timeout_d;
      m00_axi_awaddr  <= awaddr_d;
      m00_axi_awvalid <= awvalid_d;
      m00_axi_wdata   <= wdata_d;
      m00_axi_wstrb   <= wstrb_d;
      m00_axi_wvalid  <= wvalid_d;
      m00_axi_bready  <= bready_d;
      m00_axi_araddr  <= araddr_d;
      m00_axi_arvalid <= arvalid_d;
      m00_axi_rready  <= rready_d;
    end
  end

endmodule

// File: tb/tb_seg_axil_master.sv
// tb_seg_axil_master: directed bench for seg_axil_master with TIMEOUT_CYCLES = 16.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// The AXI slave side is driven directly by the directed steps.
module tb_seg_axil_master;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [3:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        rsp_timeout;
  logic [3:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  int n_tests = 0;
  int n_fail  = 0;

  seg_axil_master #(
    .C_S00_AXI_DATA_WIDTH(32),
    .C_S00_AXI_ADDR_WIDTH(4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .m00_axi_awaddr(awaddr), .m00_axi_awprot(awprot), .m00_axi_awvalid(awvalid),
    .m00_axi_awready(awready),
    .m00_axi_wdata(wdata), .m00_axi_wstrb(wstrb), .m00_axi_wvalid(wvalid),
    .m00_axi_wready(wready),
    .m00_axi_bresp(bresp), .m00_axi_bvalid(bvalid), .m00_axi_bready(bready),
    .m00_axi_araddr(araddr), .m00_axi_arprot(arprot), .m00_axi_arvalid(arvalid),
    .m00_axi_arready(arready),
    .m00_axi_rdata(rdata), .m00_axi_rresp(rresp), .m00_axi_rvalid(rvalid),
    .m00_axi_rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Presents one command for a single cycle; returns at the falling edge after acceptance.
  task automatic send_cmd(input logic we, input logic [3:0] addr,
                          input logic [31:0] data, input logic [3:0] strb);
    chk("cmd_ready_before_accept", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_wdata = data;
    cmd_wstrb = strb;
    step();
    cmd_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b0;
    awready = 1'b0; wready = 1'b0; bresp = 2'b00; bvalid = 1'b0;
    arready = 1'b0; rdata = '0; rresp = 2'b00; rvalid = 1'b0;
    step(); step();

    // reset state
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_awvalid", 32'(awvalid), 32'd0);
    chk("rst_wvalid", 32'(wvalid), 32'd0);
    chk("rst_arvalid", 32'(arvalid), 32'd0);
    chk("rst_bready", 32'(bready), 32'd0);
    chk("rst_rready", 32'(rready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
    chk("rst_prot", 32'({awprot, arprot}), 32'd0);
    rst = 1'b0;
    step();

    // write 0x4 <- 0xDEADBEEF, always-ready slave
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
    send_cmd(1'b1, 4'h4, 32'hDEADBEEF, 4'hF);
    chk("w1_awvalid_c1", 32'(awvalid), 32'd1);
    chk("w1_wvalid_c1", 32'(wvalid), 32'd1);
    chk("w1_awaddr", 32'(awaddr), 32'h4);
    chk("w1_wdata", wdata, 32'hDEADBEEF);
    chk("w1_wstrb", 32'(wstrb), 32'hF);
    chk("w1_cmd_ready_busy", 32'(cmd_ready), 32'd0);
    step();
    chk("w1_awvalid_c2", 32'(awvalid), 32'd0);
    chk("w1_wvalid_c2", 32'(wvalid), 32'd0);
    chk("w1_bready_c2", 32'(bready), 32'd1);
    chk("w1_rsp_valid_c2", 32'(rsp_valid), 32'd0);
    step();
    chk("w1_rsp_valid_c3", 32'(rsp_valid), 32'd1);
    chk("w1_rsp_resp", 32'(rsp_resp), 32'd0);
    chk("w1_rsp_timeout", 32'(rsp_timeout), 32'd0);
    chk("w1_rsp_rdata", rsp_rdata, 32'd0);
    chk("w1_bready_c3", 32'(bready), 32'd0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("w1_rsp_valid_after", 32'(rsp_valid), 32'd0);
    chk("w1_cmd_ready_after", 32'(cmd_ready), 32'd1);

    // write with awready delayed 5 cycles, wready always high
    awready = 1'b0; wready = 1'b1; bvalid = 1'b0;
    send_cmd(1'b1, 4'h8, 32'h12345678, 4'h3);
    chk("w2_awvalid_c1", 32'(awvalid), 32'd1);
    chk("w2_wvalid_c1", 32'(wvalid), 32'd1);
    for (int i = 2; i <= 5; i++) begin
      step();
      chk("w2_awvalid_held", 32'(awvalid), 32'd1);
      chk("w2_wvalid_dropped", 32'(wvalid), 32'd0);
      chk("w2_bready_early", 32'(bready), 32'd0);
    end
    step();
    chk("w2_awvalid_c6", 32'(awvalid), 32'd1);
    chk("w2_awaddr_stable", 32'(awaddr), 32'h8);
    awready = 1'b1;
    step();
    awready = 1'b0;
    chk("w2_awvalid_c7", 32'(awvalid), 32'd0);
    chk("w2_bready_c7", 32'(bready), 32'd1);
    step();
    chk("w2_rsp_before_b", 32'(rsp_valid), 32'd0);
    bvalid = 1'b1; bresp = 2'b00;
    step();
    bvalid = 1'b0;
    chk("w2_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("w2_rsp_resp", 32'(rsp_resp), 32'd0);
    chk("w2_bready_off", 32'(bready), 32'd0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // read 0xC, arready delayed 2 cycles, rvalid delayed 3 cycles
    wready = 1'b0;
    send_cmd(1'b0, 4'hC, 32'h0, 4'h0);
    chk("r1_arvalid_c1", 32'(arvalid), 32'd1);
    chk("r1_araddr", 32'(araddr), 32'hC);
    step();
    chk("r1_arvalid_c2", 32'(arvalid), 32'd1);
    step();
    chk("r1_arvalid_c3", 32'(arvalid), 32'd1);
    arready = 1'b1;
    step();
    arready = 1'b0;
    chk("r1_arvalid_c4", 32'(arvalid), 32'd0);
    chk("r1_rready_c4", 32'(rready), 32'd1);
    step();
    chk("r1_rready_c5", 32'(rready), 32'd1);
    step();
    chk("r1_rsp_before_r", 32'(rsp_valid), 32'd0);
    rvalid = 1'b1; rdata = 32'h00000005; rresp = 2'b00;
    step();
    rvalid = 1'b0; rdata = 32'hFFFFFFFF;
    chk("r1_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("r1_rsp_rdata", rsp_rdata, 32'h00000005);
    chk("r1_rsp_resp", 32'(rsp_resp), 32'd0);
    chk("r1_rready_off", 32'(rready), 32'd0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // write timeout: slave never raises awready or wready
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    send_cmd(1'b1, 4'h0, 32'hCAFEF00D, 4'hF);
    chk("t_awvalid_c1", 32'(awvalid), 32'd1);
    for (int i = 2; i <= 16; i++) step();
    chk("t_awvalid_c16", 32'(awvalid), 32'd1);
    chk("t_wvalid_c16", 32'(wvalid), 32'd1);
    chk("t_rsp_valid_c16", 32'(rsp_valid), 32'd0);
    step();
    chk("t_awvalid_c17", 32'(awvalid), 32'd0);
    chk("t_wvalid_c17", 32'(wvalid), 32'd0);
    chk("t_bready_c17", 32'(bready), 32'd0);
    chk("t_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t_rsp_resp", 32'(rsp_resp), 32'h2);
    chk("t_rsp_timeout", 32'(rsp_timeout), 32'd1);
    chk("t_rsp_rdata", rsp_rdata, 32'd0);
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
    step();
    chk("t_late_awvalid", 32'(awvalid), 32'd0);
    chk("t_late_bready", 32'(bready), 32'd0);
    chk("t_late_rsp_timeout", 32'(rsp_timeout), 32'd1);
    chk("t_late_rsp_resp", 32'(rsp_resp), 32'h2);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("t_idle_cmd_ready", 32'(cmd_ready), 32'd1);
    step();
    chk("t_idle_awvalid", 32'(awvalid), 32'd0);
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;

    // read with rresp = SLVERR, rsp_ready held low 4 cycles
    arready = 1'b1; rvalid = 1'b1; rdata = 32'hA5A50001; rresp = 2'b10;
    send_cmd(1'b0, 4'h4, 32'h0, 4'h0);
    chk("r2_arvalid_c1", 32'(arvalid), 32'd1);
    step();
    chk("r2_rready_c2", 32'(rready), 32'd1);
    step();
    rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
    for (int i = 0; i < 4; i++) begin
      chk("r2_hold_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("r2_hold_rsp_rdata", rsp_rdata, 32'hA5A50001);
      chk("r2_hold_rsp_resp", 32'(rsp_resp), 32'h2);
      chk("r2_hold_rsp_timeout", 32'(rsp_timeout), 32'd0);
      chk("r2_hold_cmd_ready", 32'(cmd_ready), 32'd0);
      if (i < 3) step();
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("r2_rsp_valid_after", 32'(rsp_valid), 32'd0);
    chk("r2_cmd_ready_after", 32'(cmd_ready), 32'd1);
    arready = 1'b0;

    // reset while waiting in WR_RESP
    awready = 1'b1; wready = 1'b1; bvalid = 1'b0;
    send_cmd(1'b1, 4'hC, 32'h0BADF00D, 4'hF);
    step();
    chk("x_bready_in_wr_resp", 32'(bready), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("x_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("x_bready", 32'(bready), 32'd0);
    chk("x_valids", 32'({awvalid, wvalid, arvalid, rready}), 32'd0);
    chk("x_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("x_rsp_fields", 32'({rsp_resp, rsp_timeout}), 32'd0);
    chk("x_rsp_rdata", rsp_rdata, 32'd0);
    chk("x_awaddr", 32'(awaddr), 32'd0);
    step();
    bvalid = 1'b1; bresp = 2'b11;
    send_cmd(1'b1, 4'h4, 32'h00000001, 4'h1);
    chk("x2_awvalid_c1", 32'(awvalid), 32'd1);
    step();
    chk("x2_bready_c2", 32'(bready), 32'd1);
    step();
    chk("x2_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("x2_rsp_resp", 32'(rsp_resp), 32'h3);
    chk("x2_rsp_timeout", 32'(rsp_timeout), 32'd0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    bvalid = 1'b0;
    chk("x2_cmd_ready_after", 32'(cmd_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
